// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the control_unit instruction sequencer:
//   - opcode_e : 4-bit instruction opcodes (IR[15:12])
//   - state_e  : 4-bit sequencer states, also exported on state_dbg
//   - ALU_*    : ALU operation select codes
//   - *_MSB/*_LSB : bit positions used to slice the instruction register
//   - alu_sel  : maps an opcode to its ALU operation select
// ---------------------------------------------------------------------------
package ctrl_pkg;

    typedef enum logic [3:0] {
        OP_NOOP  = 4'h0,
        OP_STORE = 4'h1,
        OP_LOAD  = 4'h2,
        OP_ADD   = 4'h3,
        OP_SUB   = 4'h4,
        OP_HALT  = 4'h5
    } opcode_e;

    typedef enum logic [3:0] {
        S_INIT       = 4'd0,
        S_FETCH      = 4'd1,
        S_FETCH_WAIT = 4'd2,
        S_DECODE     = 4'd3,
        S_LOAD_A     = 4'd4,
        S_LOAD_B     = 4'd5,
        S_STORE_A    = 4'd6,
        S_STORE_B    = 4'd7,
        S_ALU_A      = 4'd8,
        S_ALU_WB     = 4'd9,
        S_HALT       = 4'd10
    } state_e;

    localparam logic [2:0] ALU_NONE = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;

    // Instruction register field positions
    localparam int OPC_MSB  = 15;
    localparam int OPC_LSB  = 12;
    localparam int DADR_MSB = 11;
    localparam int DADR_LSB = 4;
    localparam int RA_MSB   = 11;
    localparam int RA_LSB   = 8;
    localparam int RB_MSB   = 7;
    localparam int RB_LSB   = 4;
    localparam int RD_MSB   = 3;
    localparam int RD_LSB   = 0;

    function automatic logic [2:0] alu_sel(input logic [3:0] opc);
        case (opc)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            default: return ALU_NONE;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// ---------------------------------------------------------------------------
// control_unit_if
// Bundles the sequencer's connections to instruction ROM, data memory,
// register file and ALU.
//   master : the control unit (drives everything except I_data)
//   slave  : the datapath / memory side
// Signals:
//   I_rd, PC_addr, I_data            instruction ROM fetch
//   D_addr, D_wr                     data memory address / write strobe
//   RF_s, RF_W_addr, RF_W_en         register file write side
//   RF_Ra_addr, RF_Rb_addr           register file read ports
//   ALU_s                            ALU operation select
//   halted, state_dbg                status / debug
// ---------------------------------------------------------------------------
interface control_unit_if #(
    parameter int PC_W = 7,
    parameter int D_AW = 8
);
    logic            I_rd;
    logic [PC_W-1:0] PC_addr;
    logic [15:0]     I_data;
    logic [D_AW-1:0] D_addr;
    logic            D_wr;
    logic            RF_s;
    logic [3:0]      RF_W_addr;
    logic            RF_W_en;
    logic [3:0]      RF_Ra_addr;
    logic [3:0]      RF_Rb_addr;
    logic [2:0]      ALU_s;
    logic            halted;
    logic [3:0]      state_dbg;

    modport master (
        output I_rd, PC_addr, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
               RF_Ra_addr, RF_Rb_addr, ALU_s, halted, state_dbg,
        input  I_data
    );

    modport slave (
        input  I_rd, PC_addr, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
               RF_Ra_addr, RF_Rb_addr, ALU_s, halted, state_dbg,
        output I_data
    );
endinterface

// File: rtl/program_counter.sv
// ---------------------------------------------------------------------------
// program_counter
// PC_W-bit program counter, wraps modulo 2^PC_W.
//   clk    : clock
//   clr    : synchronous clear (takes priority)
//   inc_en : increment by one on this edge
//   pc     : current counter value
// ---------------------------------------------------------------------------
module program_counter #(
    parameter int PC_W = 7
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            inc_en,
    output logic [PC_W-1:0] pc
);
    logic [PC_W-1:0] pc_r;

    // Counter register: clear, increment (natural wrap), or hold
    always_ff @(posedge clk) begin
        if (clr) begin
            pc_r <= '0;
        end else if (inc_en) begin
            pc_r <= pc_r + {{(PC_W-1){1'b0}}, 1'b1};
        end else begin
            pc_r <= pc_r;
        end
    end

    assign pc = pc_r;

endmodule

// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
// Multi-cycle instruction sequencer. Fetches 16-bit instructions from a
// synchronous ROM, decodes them, and drives register file / data memory /
// ALU controls for LOAD, STORE, ADD, SUB; stops on HALT.
//   clk   : clock, all state changes on rising edge
//   rst_n : synchronous active-low reset
//   bus   : control_unit_if.master (ROM, memory, register file, ALU, status)
// Outputs are registered: each edge loads the decode of the state being
// entered, so the output registers always match state_r/ir_r. The two write
// strobes are additionally gated by rst_n so nothing commits on a reset edge.
// ---------------------------------------------------------------------------
module control_unit
    import ctrl_pkg::*;
#(
    parameter int PC_W = 7,
    parameter int D_AW = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    control_unit_if.master bus
);
    state_e          state_r;
    state_e          state_next_s;
    logic [15:0]     ir_r;
    logic [15:0]     ir_next_s;
    logic [3:0]      opc_s;
    logic [3:0]      opc_next_s;
    logic [PC_W-1:0] pc_s;
    logic            pc_inc_s;

    logic            i_rd_s,      i_rd_r;
    logic [D_AW-1:0] d_addr_s,    d_addr_r;
    logic            d_wr_s,      d_wr_r;
    logic            rf_s_s,      rf_s_r;
    logic [3:0]      rf_w_addr_s, rf_w_addr_r;
    logic            rf_w_en_s,   rf_w_en_r;
    logic [3:0]      ra_addr_s,   ra_addr_r;
    logic [3:0]      rb_addr_s,   rb_addr_r;
    logic [2:0]      alu_s_s,     alu_s_r;
    logic            halted_s,    halted_r;

    assign opc_s      = ir_r[OPC_MSB:OPC_LSB];
    assign opc_next_s = ir_next_s[OPC_MSB:OPC_LSB];
    assign pc_inc_s   = (state_r == S_FETCH_WAIT);

    program_counter #(.PC_W(PC_W)) u_pc (
        .clk    (clk),
        .clr    (~rst_n),
        .inc_en (pc_inc_s),
        .pc     (pc_s)
    );

    // Next-state and next-IR selection; IR captures ROM data the cycle after I_rd
    always_comb begin
        state_next_s = state_r;
        ir_next_s    = ir_r;
        case (state_r)
            S_INIT:       state_next_s = S_FETCH;
            S_FETCH:      state_next_s = S_FETCH_WAIT;
            S_FETCH_WAIT: begin
                ir_next_s    = bus.I_data;
                state_next_s = S_DECODE;
            end
            S_DECODE: begin
                case (opc_s)
                    OP_LOAD:        state_next_s = S_LOAD_A;
                    OP_STORE:       state_next_s = S_STORE_A;
                    OP_ADD, OP_SUB: state_next_s = S_ALU_A;
                    OP_HALT:        state_next_s = S_HALT;
                    default:        state_next_s = S_FETCH;
                endcase
            end
            S_LOAD_A:     state_next_s = S_LOAD_B;
            S_LOAD_B:     state_next_s = S_FETCH;
            S_STORE_A:    state_next_s = S_STORE_B;
            S_STORE_B:    state_next_s = S_FETCH;
            S_ALU_A:      state_next_s = S_ALU_WB;
            S_ALU_WB:     state_next_s = S_FETCH;
            S_HALT:       state_next_s = S_HALT;
            default:      state_next_s = S_INIT;
        endcase
    end

    // Moore decode of the state being entered; addresses repeat in both halves
    // of each two-cycle pair so the memories see stable addresses
    always_comb begin
        i_rd_s      = 1'b0;
        d_addr_s    = '0;
        d_wr_s      = 1'b0;
        rf_s_s      = 1'b0;
        rf_w_addr_s = 4'h0;
        rf_w_en_s   = 1'b0;
        ra_addr_s   = 4'h0;
        rb_addr_s   = 4'h0;
        alu_s_s     = ALU_NONE;
        halted_s    = 1'b0;
        case (state_next_s)
            S_FETCH: i_rd_s = 1'b1;
            S_LOAD_A: begin
                d_addr_s = D_AW'(ir_next_s[DADR_MSB:DADR_LSB]);
            end
            S_LOAD_B: begin
                d_addr_s    = D_AW'(ir_next_s[DADR_MSB:DADR_LSB]);
                rf_s_s      = 1'b1;
                rf_w_addr_s = ir_next_s[RD_MSB:RD_LSB];
                rf_w_en_s   = 1'b1;
            end
            S_STORE_A: begin
                d_addr_s  = D_AW'(ir_next_s[DADR_MSB:DADR_LSB]);
                ra_addr_s = ir_next_s[RD_MSB:RD_LSB];
            end
            S_STORE_B: begin
                d_addr_s  = D_AW'(ir_next_s[DADR_MSB:DADR_LSB]);
                ra_addr_s = ir_next_s[RD_MSB:RD_LSB];
                d_wr_s    = 1'b1;
            end
            S_ALU_A: begin
                ra_addr_s = ir_next_s[RA_MSB:RA_LSB];
                rb_addr_s = ir_next_s[RB_MSB:RB_LSB];
                alu_s_s   = alu_sel(opc_next_s);
            end
            S_ALU_WB: begin
                ra_addr_s   = ir_next_s[RA_MSB:RA_LSB];
                rb_addr_s   = ir_next_s[RB_MSB:RB_LSB];
                alu_s_s     = alu_sel(opc_next_s);
                rf_s_s      = 1'b0;
                rf_w_addr_s = ir_next_s[RD_MSB:RD_LSB];
                rf_w_en_s   = 1'b1;
            end
            S_HALT:  halted_s = 1'b1;
            default: i_rd_s = 1'b0;
        endcase
    end

    // State, instruction register and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= S_INIT;
            ir_r        <= 16'h0000;
            i_rd_r      <= 1'b0;
            d_addr_r    <= '0;
            d_wr_r      <= 1'b0;
            rf_s_r      <= 1'b0;
            rf_w_addr_r <= 4'h0;
            rf_w_en_r   <= 1'b0;
            ra_addr_r   <= 4'h0;
            rb_addr_r   <= 4'h0;
            alu_s_r     <= ALU_NONE;
            halted_r    <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            ir_r        <= ir_next_s;
            i_rd_r      <= i_rd_s;
            d_addr_r    <= d_addr_s;
            d_wr_r      <= d_wr_s;
            rf_s_r      <= rf_s_s;
            rf_w_addr_r <= rf_w_addr_s;
            rf_w_en_r   <= rf_w_en_s;
            ra_addr_r   <= ra_addr_s;
            rb_addr_r   <= rb_addr_s;
            alu_s_r     <= alu_s_s;
            halted_r    <= halted_s;
        end
    end

    assign bus.I_rd       = i_rd_r;
    assign bus.PC_addr    = pc_s;
    assign bus.D_addr     = d_addr_r;
    assign bus.D_wr       = d_wr_r & rst_n;
    assign bus.RF_s       = rf_s_r;
    assign bus.RF_W_addr  = rf_w_addr_r;
    assign bus.RF_W_en    = rf_w_en_r & rst_n;
    assign bus.RF_Ra_addr = ra_addr_r;
    assign bus.RF_Rb_addr = rb_addr_r;
    assign bus.ALU_s      = alu_s_r;
    assign bus.halted     = halted_r;
    assign bus.state_dbg  = state_r;

endmodule

// File: tb/tb_control_unit.sv
// ---------------------------------------------------------------------------
// tb_control_unit
// Instruction-level model: each fetched instruction expands into its list of
// per-cycle expected outputs (fetch, wait, decode, then 0 or 2 execute
// cycles). Every cycle after reset the DUT outputs are compared against the
// head of that list. Hand-computed spot checks on captured values pin the
// model to the documented behaviour.
// ---------------------------------------------------------------------------
module tb_control_unit;
    localparam int PC_W = 7;
    localparam int D_AW = 8;
    localparam int MAXC = 512;

    typedef struct {
        int i_rd; int pc; int d_addr; int d_wr; int rf_s; int w_addr;
        int w_en; int ra; int rb; int alu; int halted;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] rom [0:127];
    logic [15:0] rom_q;

    always #5 clk = ~clk;

    control_unit_if #(.PC_W(PC_W), .D_AW(D_AW)) bus();
    control_unit #(.PC_W(PC_W), .D_AW(D_AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Synchronous instruction ROM: data valid the cycle after I_rd
    always @(posedge clk) begin
        if (bus.I_rd) rom_q <= rom[bus.PC_addr];
    end
    assign bus.I_data = rom_q;

    // Count register-file writes that actually commit on a clock edge
    int wr_cnt = 0;
    always @(posedge clk) begin
        if (bus.RF_W_en === 1'b1) wr_cnt <= wr_cnt + 1;
    end

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t q[$];
    int   pc_m;
    bit   halted_m;
    int   cap_ird[MAXC], cap_pc[MAXC], cap_daddr[MAXC], cap_dwr[MAXC];
    int   cap_rfs[MAXC], cap_waddr[MAXC], cap_wen[MAXC], cap_ra[MAXC];
    int   cap_rb[MAXC], cap_alu[MAXC], cap_halt[MAXC];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    function automatic exp_t blank(input int pc);
        exp_t e;
        e = '{default: 0};
        e.pc = pc;
        return e;
    endfunction

    // Append the expected cycles of the instruction at pc_m
    task automatic expand();
        exp_t e;
        logic [15:0] ir;
        int op;
        if (halted_m) begin
            e = blank(pc_m);
            e.halted = 1;
            q.push_back(e);
            return;
        end
        ir = rom[pc_m];
        op = int'(ir[15:12]);
        e = blank(pc_m); e.i_rd = 1; q.push_back(e);
        e = blank(pc_m); q.push_back(e);
        pc_m = (pc_m + 1) % 128;
        e = blank(pc_m); q.push_back(e);
        case (op)
            1: begin
                e.d_addr = int'(ir[11:4]); e.ra = int'(ir[3:0]); q.push_back(e);
                e.d_wr = 1; q.push_back(e);
            end
            2: begin
                e.d_addr = int'(ir[11:4]); q.push_back(e);
                e.rf_s = 1; e.w_addr = int'(ir[3:0]); e.w_en = 1; q.push_back(e);
            end
            3, 4: begin
                e.ra = int'(ir[11:8]); e.rb = int'(ir[7:4]);
                e.alu = (op == 3) ? 1 : 2; q.push_back(e);
                e.w_addr = int'(ir[3:0]); e.w_en = 1; q.push_back(e);
            end
            5: halted_m = 1'b1;
            default: ;
        endcase
    endtask

    task automatic model_reset();
        q.delete();
        pc_m = 0;
        halted_m = 1'b0;
        q.push_back(blank(0));
        cyc = 0;
    endtask

    task automatic sample_cycle();
        exp_t e;
        if (q.size() == 0) expand();
        e = q.pop_front();
        if (cyc < MAXC) begin
            cap_ird[cyc] = int'(bus.I_rd);       cap_pc[cyc]    = int'(bus.PC_addr);
            cap_daddr[cyc] = int'(bus.D_addr);   cap_dwr[cyc]   = int'(bus.D_wr);
            cap_rfs[cyc] = int'(bus.RF_s);       cap_waddr[cyc] = int'(bus.RF_W_addr);
            cap_wen[cyc] = int'(bus.RF_W_en);    cap_ra[cyc]    = int'(bus.RF_Ra_addr);
            cap_rb[cyc] = int'(bus.RF_Rb_addr);  cap_alu[cyc]   = int'(bus.ALU_s);
            cap_halt[cyc] = int'(bus.halted);
        end
        check("I_rd", int'(bus.I_rd), e.i_rd);
        check("PC_addr", int'(bus.PC_addr), e.pc);
        check("D_addr", int'(bus.D_addr), e.d_addr);
        check("D_wr", int'(bus.D_wr), e.d_wr);
        check("RF_s", int'(bus.RF_s), e.rf_s);
        check("RF_W_addr", int'(bus.RF_W_addr), e.w_addr);
        check("RF_W_en", int'(bus.RF_W_en), e.w_en);
        check("RF_Ra_addr", int'(bus.RF_Ra_addr), e.ra);
        check("RF_Rb_addr", int'(bus.RF_Rb_addr), e.rb);
        check("ALU_s", int'(bus.ALU_s), e.alu);
        check("halted", int'(bus.halted), e.halted);
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            sample_cycle();
            @(negedge clk);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_I_rd"}, int'(bus.I_rd), 0);
        check({tag, "_PC"}, int'(bus.PC_addr), 0);
        check({tag, "_D_addr"}, int'(bus.D_addr), 0);
        check({tag, "_D_wr"}, int'(bus.D_wr), 0);
        check({tag, "_RF_W_en"}, int'(bus.RF_W_en), 0);
        check({tag, "_RF_Ra"}, int'(bus.RF_Ra_addr), 0);
        check({tag, "_ALU_s"}, int'(bus.ALU_s), 0);
        check({tag, "_halted"}, int'(bus.halted), 0);
        check({tag, "_state_dbg"}, int'(bus.state_dbg), 0);
    endtask

    // Two reset edges, check reset state, then release: caller is in cycle 0 (INIT)
    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic fill_rom(input logic [15:0] v);
        for (int i = 0; i < 128; i++) rom[i] = v;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s, w0;

        // NOOP, NOOP, undefined opcode, HALT
        fill_rom(16'h0000);
        rom[2] = 16'h7ABC;
        rom[3] = 16'h5000;
        do_reset();
        run(16);
        check("noop_ird_c1", cap_ird[1], 1);
        check("noop_ird_c2", cap_ird[2], 0);
        check("noop_ird_c4", cap_ird[4], 1);
        check("noop_pc_after_2nd_fetch", cap_pc[6], 2);
        check("undef_3cyc_ird_c10", cap_ird[10], 1);
        check("halt_c12", cap_halt[12], 0);
        check("halt_c13", cap_halt[13], 1);
        check("halt_pc_frozen", cap_pc[15], 4);

        // LOAD, ADD, SUB, STORE, HALT
        fill_rom(16'h0000);
        rom[0] = 16'h21F3;
        rom[1] = 16'h3124;
        rom[2] = 16'h4415;
        rom[3] = 16'h1804;
        rom[4] = 16'h5000;
        do_reset();
        run(28);
        check("load_daddr_a", cap_daddr[4], 8'h1F);
        check("load_wen_a", cap_wen[4], 0);
        check("load_daddr_b", cap_daddr[5], 8'h1F);
        check("load_rfs_b", cap_rfs[5], 1);
        check("load_waddr_b", cap_waddr[5], 3);
        check("load_wen_b", cap_wen[5], 1);
        s = 0;
        for (int i = 1; i < 10; i++) s += cap_wen[i];
        check("load_wen_one_cycle", s, 1);
        check("add_fetch_c6", cap_ird[6], 1);
        check("add_ra", cap_ra[9], 1);
        check("add_rb", cap_rb[9], 2);
        check("add_alu", cap_alu[9], 1);
        check("add_waddr", cap_waddr[10], 4);
        check("sub_fetch_c11", cap_ird[11], 1);
        check("sub_alu", cap_alu[14], 2);
        check("sub_ra", cap_ra[15], 4);
        check("sub_waddr", cap_waddr[15], 5);
        check("store_dwr_a", cap_dwr[19], 0);
        check("store_dwr_b", cap_dwr[20], 1);
        check("store_daddr_a", cap_daddr[19], 8'h80);
        check("store_daddr_b", cap_daddr[20], 8'h80);
        check("store_ra_a", cap_ra[19], 4);
        check("store_ra_b", cap_ra[20], 4);
        check("halt_c24", cap_halt[24], 1);

        // Reset asserted during ALU_WB of an ADD
        fill_rom(16'h0000);
        rom[0] = 16'h3124;
        do_reset();
        run(5);
        sample_cycle();
        w0 = wr_cnt;
        rst_n = 1'b0;
        #1;
        check("rst_gates_RF_W_en", int'(bus.RF_W_en), 0);
        check("rst_gates_D_wr", int'(bus.D_wr), 0);
        @(posedge clk);
        #1;
        check("no_write_on_reset_edge", wr_cnt - w0, 0);
        @(negedge clk);
        check_all_zero("midrst");
        rst_n = 1'b1;
        model_reset();
        run(12);
        check("restart_fetch_c1", cap_ird[1], 1);
        check("restart_pc_c1", cap_pc[1], 0);
        check("restart_wen_c5", cap_wen[5], 1);

        // PC wrap: 128 NOOPs, then HALT placed at address 0
        fill_rom(16'h0000);
        do_reset();
        run(10);
        rom[0] = 16'h5000;
        run(395);
        check("wrap_fetch_127_ird", cap_ird[382], 1);
        check("wrap_fetch_127_pc", cap_pc[382], 127);
        check("wrap_pc_zero", cap_pc[384], 0);
        check("wrap_refetch_0", cap_ird[385], 1);
        check("wrap_halt_c387", cap_halt[387], 0);
        check("wrap_halt_c388", cap_halt[388], 1);
        s = 0;
        for (int i = 386; i < 405; i++) s += cap_ird[i];
        check("wrap_no_ird_after_halt", s, 0);
        check("wrap_pc_frozen", cap_pc[404], 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
